mc_datapath: RTL and testbench

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/dp_pkg.sv | 45 ++++
 rtl/dp_seq_mul.sv | 65 ++++++
 rtl/mc_datapath.sv | 241 ++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg -- shared definitions for the multi-cycle datapath.
//
// Contents:
//   OP_*        3-bit opcode encodings
//   dpState_e   controller state enum (IDLE, FETCH, EXEC, [MUL,] WB)
//   MUL_EN      1 when the iterative multiplier is built in
//   opIsLegal   tells whether an opcode is executable in this build
//
// Configuration macro: DP_MUL_EN. When it is defined, the MUL state and
// the MUL opcode exist. When it is not defined, MUL is an illegal opcode
// and MFHI reads zero.

package dp_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_MFHI = 3'b111;

`ifdef DP_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
`ifdef DP_MUL_EN
        MUL   = 3'd3,
`endif
        WB    = 3'd4
    } dpState_e;

    // MUL is the only opcode that can be missing from a build.
    function automatic logic opIsLegal(input logic [2:0] op);
        return MUL_EN || (op != OP_MUL);
    endfunction

endpackage

// File: rtl/dp_seq_mul.sv
// dp_seq_mul -- unsigned shift-add multiplier, one partial product per cycle.
//
// Ports:
//   clock  rising-edge clock
//   clear  asynchronous active-high reset
//   start  load a/b and begin (ignored while busy)
//   a, b   DATA_W-bit unsigned operands
//   busy   high while the DATA_W iteration steps are running
//   done   high during the last iteration cycle; {hi,lo} is final after it
//   hi,lo  2*DATA_W-bit product
//
// Only built when the DP_MUL_EN macro is defined.

`ifdef DP_MUL_EN
module dp_seq_mul #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  stepCount;
    logic [DATA_W-1:0] multiplicand;
    logic [DATA_W:0]   partialSum;

    // lo starts as the multiplier and is shifted out one bit per step, so
    // lo[0] always holds the multiplier bit for the current step.
    assign partialSum = {1'b0, hi} + (lo[0] ? {1'b0, multiplicand} : '0);
    assign done       = busy && (stepCount == CNT_W'(DATA_W - 1));

    // One step per busy cycle: add, then shift the whole {hi,lo} pair right
    // with the carry entering at the top.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            busy         <= 1'b0;
            stepCount    <= '0;
            multiplicand <= '0;
            hi           <= '0;
            lo           <= '0;
        end else if (start && !busy) begin
            busy         <= 1'b1;
            stepCount    <= '0;
            multiplicand <= a;
            hi           <= '0;
            lo           <= b;
        end else if (busy) begin
            {hi, lo}  <= {partialSum, lo[DATA_W-1:1]};
            stepCount <= stepCount + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/mc_datapath.sv
// mc_datapath -- multi-cycle register-file datapath with a small controller.
//
// Ports:
//   clock             rising-edge clock
//   clear             asynchronous active-high reset
//   start             run one instruction (accepted only in IDLE)
//   op, ra, rb, rc    opcode, destination, source A, source B
//   imm               16-bit immediate, sign-extended for ADDI
//   ld_en/ld_addr/ld_data  external register load (IDLE with start low only)
//   dbg_addr/dbg_data combinational register read port
//   busy              high in every non-IDLE state
//   done              one-cycle pulse in WB
//   err               one-cycle pulse with done for an illegal opcode
//
// Configuration macro: DP_MUL_EN builds the iterative multiplier, the MUL
// state and the HI register. Without it, opcode 110 is illegal and MFHI
// writes zero.

module mc_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    input  logic [$clog2(NREGS)-1:0] rc,
    input  logic [15:0]              imm,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int RA_W = $clog2(NREGS);
    localparam int SH_W = $clog2(DATA_W);

    dpState_e          state;
    dpState_e          nextState;

    logic [2:0]        opReg;
    logic [RA_W-1:0]   raReg;
    logic [RA_W-1:0]   rbReg;
    logic [RA_W-1:0]   rcReg;
    logic [15:0]       immReg;

    logic [DATA_W-1:0] regFile [NREGS];
    logic [DATA_W-1:0] ry;
    logic [DATA_W-1:0] z;
    logic [DATA_W-1:0] operandB;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] wbData;
    logic              legalOp;
    logic              wbWrite;
    logic              ldWrite;

`ifdef DP_MUL_EN
    logic              mulStart;
    logic              mulBusy;
    logic              mulDone;
    logic [DATA_W-1:0] mulHi;
    logic [DATA_W-1:0] mulLo;
    logic [DATA_W-1:0] hiReg;
`endif

    assign legalOp  = opIsLegal(opReg);
    assign wbWrite  = (state == WB) && legalOp;
    assign ldWrite  = (state == IDLE) && !start && ld_en;
    assign dbg_data = regFile[dbg_addr];
    assign operandB = (opReg == OP_ADDI) ? DATA_W'($signed(immReg)) : regFile[rcReg];

    // Controller state register; clear aborts any instruction in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and status outputs. Illegal opcodes follow the normal
    // FETCH/EXEC/WB path; only the register write is suppressed.
    always_comb begin
        nextState = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                nextState = EXEC;
`ifdef DP_MUL_EN
                if (opReg == OP_MUL) begin
                    nextState = MUL;
                end
`endif
            end
            EXEC: begin
                nextState = WB;
            end
`ifdef DP_MUL_EN
            MUL: begin
                if (mulDone) begin
                    nextState = WB;
                end
            end
`endif
            WB: begin
                done      = 1'b1;
                err       = !legalOp;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Instruction fields are captured once so the inputs may change freely
    // while the instruction runs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            opReg  <= '0;
            raReg  <= '0;
            rbReg  <= '0;
            rcReg  <= '0;
            immReg <= '0;
        end else if ((state == IDLE) && start) begin
            opReg  <= op;
            raReg  <= ra;
            rbReg  <= rb;
            rcReg  <= rc;
            immReg <= imm;
        end
    end

    // ALU. SHL uses only the low SH_W bits of B, so it can never shift
    // everything out. MUL/MFHI do not use Z, which keeps its value.
    always_comb begin
        aluResult = z;
        case (opReg)
            OP_ADD:  aluResult = ry + operandB;
            OP_SUB:  aluResult = ry - operandB;
            OP_AND:  aluResult = ry & operandB;
            OP_OR:   aluResult = ry | operandB;
            OP_ADDI: aluResult = ry + operandB;
            OP_SHL:  aluResult = ry << operandB[SH_W-1:0];
            default: aluResult = z;
        endcase
    end

    // Operand A is staged in RY during FETCH; the result is staged in Z
    // during EXEC.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ry <= '0;
            z  <= '0;
        end else begin
            if (state == FETCH) begin
                ry <= regFile[rbReg];
            end
            if (state == EXEC) begin
                z <= aluResult;
            end
        end
    end

`ifdef DP_MUL_EN
    // The multiplier reads the register file directly in FETCH, so its
    // DATA_W steps line up exactly with the DATA_W cycles spent in MUL.
    assign mulStart = (state == FETCH) && (opReg == OP_MUL) && !mulBusy;

    dp_seq_mul #(
        .DATA_W(DATA_W)
    ) uMul (
        .clock (clock),
        .clear (clear),
        .start (mulStart),
        .a     (regFile[rbReg]),
        .b     (regFile[rcReg]),
        .busy  (mulBusy),
        .done  (mulDone),
        .hi    (mulHi),
        .lo    (mulLo)
    );

    // HI moves only when a multiply completes, so MFHI keeps returning the
    // last product even though the multiplier's own registers are reloaded.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hiReg <= '0;
        end else if ((state == WB) && (opReg == OP_MUL)) begin
            hiReg <= mulHi;
        end
    end
`endif

    // Write-back source selection.
    always_comb begin
        wbData = z;
`ifdef DP_MUL_EN
        if (opReg == OP_MUL) begin
            wbData = mulLo;
        end else if (opReg == OP_MFHI) begin
            wbData = hiReg;
        end
`else
        if (opReg == OP_MFHI) begin
            wbData = '0;
        end
`endif
    end

    // Register file. R0 is never written, so it always reads zero. The
    // write-back and the external load occur in different states and can
    // never collide.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbWrite && (raReg != '0)) begin
            regFile[raReg] <= wbData;
        end else if (ldWrite && (ld_addr != '0)) begin
            regFile[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath -- self-checking bench for mc_datapath.
// It runs a 32-bit/16-register instance and, for the narrow shift case,
// a 16-bit/8-register instance. Expected values come from a behavioural
// register/HI model. The bench honours the DP_MUL_EN macro.

module tb_mc_datapath;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int RW = 4;

`ifdef DP_MUL_EN
    localparam bit TB_MUL = 1'b1;
`else
    localparam bit TB_MUL = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [2:0]    op;
    logic [RW-1:0] ra, rb, rc;
    logic [15:0]   imm;
    logic          ld_en;
    logic [RW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [RW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          busy, done, err;

    logic          smallStart;
    logic [2:0]    smallOp;
    logic [2:0]    smallRa, smallRb, smallRc;
    logic [15:0]   smallImm;
    logic          smallLdEn;
    logic [2:0]    smallLdAddr;
    logic [15:0]   smallLdData;
    logic [2:0]    smallDbgAddr;
    logic [15:0]   smallDbgData;
    logic          smallBusy, smallDone, smallErr;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [NR];
    logic [DW-1:0] modelHi;

    always #5 clock = ~clock;

    mc_datapath #(.DATA_W(DW), .NREGS(NR)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done), .err(err)
    );

    mc_datapath #(.DATA_W(16), .NREGS(8)) dutSmall (
        .clock(clock), .clear(clear), .start(smallStart), .op(smallOp),
        .ra(smallRa), .rb(smallRb), .rc(smallRc), .imm(smallImm),
        .ld_en(smallLdEn), .ld_addr(smallLdAddr), .ld_data(smallLdData),
        .dbg_addr(smallDbgAddr), .dbg_data(smallDbgData),
        .busy(smallBusy), .done(smallDone), .err(smallErr)
    );

    typedef struct {
        logic [2:0]    op;
        int            ra, rb, rc;
        logic [15:0]   imm;
        logic [DW-1:0] expVal;
        string         name;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Reference semantics of one instruction on the model state.
    function automatic void refExec(input logic [2:0] o, input int d, input int s1,
                                    input int s2, input logic [15:0] im,
                                    output logic illegal);
        logic [DW-1:0] a, b, val;
        logic [63:0]   prod;
        logic          wr;
        a = model[s1];
        b = model[s2];
        illegal = 1'b0;
        wr = 1'b1;
        prod = {32'h0, a} * {32'h0, b};
        case (o)
            3'd0: val = a + b;
            3'd1: val = a - b;
            3'd2: val = a & b;
            3'd3: val = a | b;
            3'd4: val = a + (im[15] ? {16'hFFFF, im} : {16'h0000, im});
            3'd5: val = a << (b % DW);
            3'd6: begin
                if (TB_MUL) begin
                    val = prod[31:0];
                    modelHi = prod[63:32];
                end else begin
                    val = '0;
                    illegal = 1'b1;
                    wr = 1'b0;
                end
            end
            default: val = TB_MUL ? modelHi : 32'h0;
        endcase
        if (wr && d != 0) model[d] = val;
    endfunction

    task automatic ldReg(input int idx, input logic [DW-1:0] val);
        @(negedge clock);
        ld_en = 1'b1;
        ld_addr = RW'(idx);
        ld_data = val;
        @(negedge clock);
        ld_en = 1'b0;
        if (idx != 0) model[idx] = val;
    endtask

    // Runs one instruction, checks latency, busy span, err and the result.
    task automatic applyStimulus(input logic [2:0] o, input int d, input int s1,
                                 input int s2, input logic [15:0] im, input string name);
        logic expIll;
        int   cyc, busyCyc, latency;
        refExec(o, d, s1, s2, im, expIll);
        latency = (o == 3'd6 && TB_MUL) ? DW + 2 : 3;
        @(negedge clock);
        start = 1'b1; op = o; ra = RW'(d); rb = RW'(s1); rc = RW'(s2); imm = im;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        busyCyc = 0;
        while (!done && cyc < latency + 5) begin
            if (busy) busyCyc++;
            @(negedge clock);
            cyc++;
        end
        if (busy) busyCyc++;
        checkOutput({name, ".latency"}, 64'(cyc), 64'(latency));
        checkOutput({name, ".busyCycles"}, 64'(busyCyc), 64'(latency));
        checkOutput({name, ".err"}, 64'(err), 64'(expIll));
        @(negedge clock);
        checkOutput({name, ".busyAfter"}, 64'(busy), 64'(0));
        dbg_addr = RW'(d);
        #1;
        checkOutput({name, ".value"}, 64'(dbg_data), 64'(model[d]));
    endtask

    task automatic checkAllZero(input string name);
        logic anyNonZero;
        anyNonZero = 1'b0;
        for (int i = 0; i < NR; i++) begin
            dbg_addr = RW'(i);
            #1;
            if (dbg_data != '0) anyNonZero = 1'b1;
        end
        checkOutput(name, 64'(anyNonZero), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        logic sawDone;
        logic dummyIll;

        clear = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        smallStart = 1'b0; smallOp = '0; smallRa = '0; smallRb = '0; smallRc = '0;
        smallImm = '0; smallLdEn = 1'b0; smallLdAddr = '0; smallLdData = '0;
        smallDbgAddr = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        modelHi = '0;

        repeat (2) @(negedge clock);
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.err", 64'(err), 64'(0));
        checkAllZero("reset.regsZero");
        clear = 1'b0;

        // Narrow instance: shift amount is masked to 4 bits (0x13 -> 3).
        @(negedge clock);
        smallLdEn = 1'b1; smallLdAddr = 3'd1; smallLdData = 16'h0001;
        @(negedge clock);
        smallLdAddr = 3'd2; smallLdData = 16'h0013;
        @(negedge clock);
        smallLdEn = 1'b0;
        smallStart = 1'b1; smallOp = 3'b101; smallRa = 3'd3; smallRb = 3'd1; smallRc = 3'd2;
        @(negedge clock);
        smallStart = 1'b0;
        cyc = 1;
        while (!smallDone && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("small.shl.latency", 64'(cyc), 64'(3));
        @(negedge clock);
        smallDbgAddr = 3'd3;
        #1;
        checkOutput("small.shl.value", 64'(smallDbgData), 64'h0008);

        // Directed table with R1=5, R2=7.
        vecs[0] = '{3'd0, 3, 1, 2, 16'h0000, 32'd12, "add"};
        vecs[1] = '{3'd1, 4, 1, 2, 16'h0000, 32'hFFFFFFFE, "sub"};
        vecs[2] = '{3'd4, 5, 1, 0, 16'hFFFF, 32'd4, "addiNeg"};
        vecs[3] = '{3'd2, 8, 1, 2, 16'h0000, 32'd5, "and"};
        vecs[4] = '{3'd3, 9, 1, 2, 16'h0000, 32'd7, "or"};
        vecs[5] = '{3'd5, 10, 1, 2, 16'h0000, 32'h00000280, "shl"};
        vecs[6] = '{3'd5, 11, 2, 4, 16'h0000, 32'hC0000000, "shlMasked"};
        vecs[7] = '{3'd0, 0, 1, 2, 16'h0000, 32'd0, "addToR0"};
        vecs[8] = '{3'd7, 12, 0, 0, 16'h0000, 32'd0, "mfhiAfterReset"};
        vecs[9] = '{3'd4, 13, 0, 0, 16'h8000, 32'hFFFF8000, "addiSext"};

        ldReg(1, 32'd5);
        ldReg(2, 32'd7);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].imm, vecs[i].name);
            checkOutput({vecs[i].name, ".table"}, 64'(dbg_data), 64'(vecs[i].expVal));
        end

        ldReg(0, 32'hDEADBEEF);
        dbg_addr = '0;
        #1;
        checkOutput("ldR0.value", 64'(dbg_data), 64'(0));

        // Multiply / illegal-opcode case and the HI read-back.
        ldReg(1, 32'hFFFFFFFF);
        ldReg(2, 32'd2);
        applyStimulus(3'd6, 6, 1, 2, 16'h0, "mul");
        checkOutput("mul.r6", 64'(dbg_data), TB_MUL ? 64'hFFFFFFFE : 64'h0);
        applyStimulus(3'd7, 7, 0, 0, 16'h0, "mfhi");
        checkOutput("mfhi.r7", 64'(dbg_data), TB_MUL ? 64'h1 : 64'h0);

        // start/ld while busy are ignored; ld with start in IDLE is ignored.
        refExec(3'd0, 14, 1, 2, 16'h0, dummyIll);
        @(negedge clock);
        start = 1'b1; op = 3'd0; ra = 4'd14; rb = 4'd1; rc = 4'd2;
        ld_en = 1'b1; ld_addr = 4'd11; ld_data = 32'h5555AAAA;
        @(negedge clock);
        op = 3'd1; ra = 4'd15; ld_addr = 4'd1; ld_data = 32'h12345678;
        @(negedge clock);
        start = 1'b0; ld_en = 1'b0;
        cyc = 2;
        while (!done && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("ignore.latency", 64'(cyc), 64'(3));
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("ignore.noSecondRun", 64'(sawDone), 64'(0));
        dbg_addr = 4'd14; #1;
        checkOutput("ignore.r14", 64'(dbg_data), 64'(1));
        dbg_addr = 4'd15; #1;
        checkOutput("ignore.r15", 64'(dbg_data), 64'(model[15]));
        dbg_addr = 4'd1; #1;
        checkOutput("ignore.r1", 64'(dbg_data), 64'hFFFFFFFF);
        dbg_addr = 4'd11; #1;
        checkOutput("ignore.r11", 64'(dbg_data), 64'(model[11]));

        // Randomized instructions against the model.
        for (int i = 1; i < NR; i++) ldReg(i, $urandom);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, NR - 1),
                          $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                          16'($urandom), $sformatf("rand%0d", i));
        end

        // Asynchronous clear in the middle of an instruction.
        @(negedge clock);
        start = 1'b1; op = 3'd6; ra = 4'd6; rb = 4'd1; rc = 4'd2;
        @(negedge clock);
        start = 1'b0;
        repeat (TB_MUL ? 10 : 1) @(negedge clock);
        #2;
        clear = 1'b1;
        #1;
        checkOutput("clear.busy", 64'(busy), 64'(0));
        checkOutput("clear.done", 64'(done), 64'(0));
        checkAllZero("clear.regsZero");
        for (int i = 0; i < NR; i++) model[i] = '0;
        modelHi = '0;
        @(negedge clock);
        clear = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < DW + 5; i++) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
        end
        checkOutput("clear.noDone", 64'(sawDone), 64'(0));
        applyStimulus(3'd7, 7, 0, 0, 16'h0, "mfhiAfterClear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
